// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder slice plus a carry flip-flop,
// operands shifted through LSB first behind a start/done handshake.
module serial_add_sub #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a_input,
   input  logic [WIDTH-1:0] b_input,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, b_q, result_q;
   logic [CntW-1:0]   cnt_q;
   logic              c_q, carry_q, ovf_q;

   logic              sum_bit, carry_nxt, last_bit, load;

   // Single full-adder slice shared by every bit position
   assign sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
   assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
   assign last_bit  = (cnt_q == CntW'(WIDTH - 1));
   assign load      = (state_q == StIdle) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (last_bit) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q != StIdle);
      done = (state_q == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (load) begin
         // Subtraction as A + ~B + 1: the +1 enters through the carry flip-flop
         a_q      <= a_input;
         b_q      <= sub ? ~b_input : b_input;
         c_q      <= sub;
         cnt_q    <= '0;
         result_q <= '0;
      end else if (state_q == StRun) begin
         a_q      <= a_q >> 1;
         b_q      <= b_q >> 1;
         c_q      <= carry_nxt;
         cnt_q    <= cnt_q + CntW'(1);
         result_q <= {sum_bit, result_q[WIDTH-1:1]};
         if (last_bit) begin
            carry_q <= carry_nxt;
            ovf_q   <= c_q ^ carry_nxt;
         end
      end
   end

   assign result    = result_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: expected results are queued at start and
// compared when done pulses.
module tb_serial_add_sub;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [W-1:0] a_input;
   logic [W-1:0] b_input;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   int   errors   = 0;
   int   checks   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   int   t_done   = 0;
   exp_t sb[$];

   serial_add_sub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sub       (sub),
      .a_input   (a_input),
      .b_input   (b_input),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] bb;
      logic [W:0]   sum;
      exp_t         e;
      bb    = s ? ~b : b;
      sum   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
      e.res = sum[W-1:0];
      e.co  = sum[W];
      e.ov  = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit track);
      start   = 1'b1;
      sub     = s;
      a_input = a;
      b_input = b;
      @(posedge clk);
      #1;
      start   = 1'b0;
      a_input = ~a;
      b_input = ~b;
      if (track) sb.push_back(model(s, a, b));
      check("busy_after_start", 32'(busy), 32'(1));
   endtask

   task automatic wait_done(input string tag, output int lat);
      exp_t e;
      lat = 0;
      while (done !== 1'b1 && lat < 4 * W) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (done !== 1'b1) begin
         check({tag, "_timeout"}, 32'(done), 32'(1));
      end else begin
         t_done = cyc;
         if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'(1));
         end else begin
            e = sb.pop_front();
            check({tag, "_res"}, 32'(result), 32'(e.res));
            check({tag, "_co"}, 32'(carry_out), 32'(e.co));
            check({tag, "_ov"}, 32'(overflow), 32'(e.ov));
            check({tag, "_busy"}, 32'(busy), 32'(1));
         end
      end
   endtask

   task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b);
      int   lat;
      exp_t e;
      e = model(s, a, b);
      start_op(s, a, b, 1'b1);
      wait_done(tag, lat);
      // done is visible in the cycle after edge W, counting the accepting edge as 0
      check({tag, "_lat"}, 32'(lat), 32'(W));
      @(posedge clk);
      #1;
      check({tag, "_done_low"}, 32'(done), 32'(0));
      check({tag, "_idle"}, 32'(busy), 32'(0));
      check({tag, "_hold"}, 32'(result), 32'(e.res));
   endtask

   initial begin
      int lat;
      int t1;
      int d0;

      rst_n   = 1'b0;
      start   = 1'b0;
      sub     = 1'b0;
      a_input = '0;
      b_input = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_result", 32'(result), 32'(0));
      check("rst_co", 32'(carry_out), 32'(0));
      check("rst_ov", 32'(overflow), 32'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("add_35_4a", 1'b0, 8'h35, 8'h4A);
      run_op("add_ff_01", 1'b0, 8'hFF, 8'h01);
      run_op("add_7f_01", 1'b0, 8'h7F, 8'h01);
      run_op("sub_10_01", 1'b1, 8'h10, 8'h01);
      run_op("sub_00_01", 1'b1, 8'h00, 8'h01);
      run_op("sub_80_01", 1'b1, 8'h80, 8'h01);
      for (int i = 0; i < 6; i++) begin
         run_op("rand", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      end

      // Starts during RUN and during DONE must be ignored
      d0 = done_cnt;
      start_op(1'b0, 8'h12, 8'h34, 1'b1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      start   = 1'b1;
      sub     = 1'b1;
      a_input = 8'hAA;
      b_input = 8'hBB;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("ign", lat);
      check("ign_lat", 32'(lat + 3), 32'(W));
      start   = 1'b1;
      sub     = 1'b1;
      a_input = 8'hFF;
      b_input = 8'hFF;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("ign_done_low", 32'(done), 32'(0));
      check("ign_busy_low", 32'(busy), 32'(0));
      check("ign_result", 32'(result), 32'(8'h46));
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("ign_not_accepted", 32'(busy), 32'(0));
      check("ign_one_done", 32'(done_cnt - d0), 32'(1));

      // Asynchronous reset mid-RUN aborts with no done
      d0 = done_cnt;
      start_op(1'b0, 8'h55, 8'h66, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_done", 32'(done), 32'(0));
      check("abort_result", 32'(result), 32'(0));
      check("abort_co", 32'(carry_out), 32'(0));
      check("abort_ov", 32'(overflow), 32'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (W + 2) begin
         @(posedge clk);
         #1;
      end
      check("abort_no_done", 32'(done_cnt - d0), 32'(0));
      run_op("post_reset_add", 1'b0, 8'h01, 8'h02);

      // Back-to-back: second start in the first IDLE cycle after DONE
      start_op(1'b0, 8'h20, 8'h22, 1'b1);
      wait_done("b2b_first", lat);
      t1 = t_done;
      @(posedge clk);
      #1;
      check("b2b_idle_gap", 32'(busy), 32'(0));
      start_op(1'b1, 8'h05, 8'h09, 1'b1);
      wait_done("b2b_second", lat);
      check("b2b_spacing", 32'(t_done - t1), 32'(W + 2));
      check("b2b_sb_drained", 32'(sb.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
